ramreader_stream: RTL and testbench

- Read-side companion to the sample RAM writer.
- Counts each committed write (a one-cycle write-bit pulse from the writer) and reads the corresponding 64-bit word from the RAM's read port, in address order.
- Splits each word into four 16-bit samples and presents them on a valid/ready stream for the downstream consumer (UART/packetiser).
- Reports backlog depth and a sticky overrun flag.

---
 rtl/ramreader_stream.sv | 107 ++++++++++
 tb/tb_ramreader_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ramreader_stream.sv
// ramreader_stream: counts committed writes, reads each new 64-bit word
// from the sample RAM in address order and streams it out as four
// 16-bit samples on a valid/ready interface.
module ramreader_stream #(
   parameter int                ADDR_W     = 14,
   parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(2),
   parameter int                RD_LATENCY = 2,
   parameter int                DEPTH      = 16384
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wbit,
   output logic [ADDR_W-1:0] o_rd_address,
   output logic              o_rden,
   input  logic [63:0]       i_q,
   output logic [15:0]       o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [ADDR_W:0]   o_pending,
   output logic              o_overrun,
   input  logic              i_clear_overrun
);

   localparam int                NUM_LANES = 4;
   localparam int                LANE_W    = 16;
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [1:0]        LAST_LANE = 2'(NUM_LANES-1);

   typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

   state_t                             state, state_nxt;
   logic [RD_LATENCY:1]                vld_pipe;
   logic [NUM_LANES-1:0][LANE_W-1:0]   hold;
   logic [1:0]                         lane_idx;
   logic                               hs, capture, full, inc, dec;

   assign hs      = o_valid & i_ready;
   assign capture = (state == WAIT) & vld_pipe[RD_LATENCY];
   assign o_data  = hold[lane_idx];
   assign full    = (o_pending == DEPTH_C);
   assign inc     = i_wbit & ~o_rden;
   assign dec     = o_rden & ~i_wbit;

   // state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next state and read issue; a new read only starts from IDLE, so the
   // RAM is never read again until all lanes of the last word are taken
   always_comb begin
      state_nxt = state;
      o_rden    = 1'b0;
      case (state)
         IDLE: if (o_pending != '0) begin
            o_rden    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (vld_pipe[RD_LATENCY]) state_nxt = SEND;
         SEND: if (hs && lane_idx == LAST_LANE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // read-latency tracker: bit k is high k cycles after the o_rden pulse
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= o_rden;
         for (int k = 2; k <= RD_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
      end
   end

   // capture the RAM word once, then step through the lanes on handshakes
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hold         <= '0;
         lane_idx     <= '0;
         o_valid      <= 1'b0;
         o_rd_address <= START_ADDR;
      end else if (capture) begin
         hold         <= i_q;
         lane_idx     <= '0;
         o_valid      <= 1'b1;
         o_rd_address <= o_rd_address + 1'b1;
      end else if (hs) begin
         lane_idx <= lane_idx + 1'b1;
         if (lane_idx == LAST_LANE) o_valid <= 1'b0;
      end
   end

   // backlog counter; a commit at full depth is an overrun (set beats clear)
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pending <= '0;
         o_overrun <= 1'b0;
      end else begin
         if (inc && !full)  o_pending <= o_pending + 1'b1;
         else if (dec)      o_pending <= o_pending - 1'b1;
         if (inc && full)          o_overrun <= 1'b1;
         else if (i_clear_overrun) o_overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ramreader_stream.sv
// Directed bench for ramreader_stream with a latency-2 RAM model whose
// output is only meaningful on the single cycle the word is due.
module tb_ramreader_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wbit = 1'b0, ready = 1'b0, clr = 1'b0;
   logic [63:0] q;
   logic [13:0] addr;
   logic        rden, valid, overrun;
   logic [15:0] data;
   logic [14:0] pending;

   logic        w_wbit = 1'b0, w_ready = 1'b1, w_clr = 1'b0;
   logic [63:0] w_q;
   logic [13:0] w_addr;
   logic        w_rden, w_valid, w_overrun;
   logic [15:0] w_data;
   logic [14:0] w_pending;

   int total = 0, bad = 0, cyc = 0;
   logic [13:0] rd_q[$], w_rd_q[$];
   int          rd_cyc[$];
   logic [15:0] hs_q[$], w_hs_q[$];
   int          hs_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ramreader_stream dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wbit(wbit), .o_rd_address(addr),
      .o_rden(rden), .i_q(q), .o_data(data), .o_valid(valid),
      .i_ready(ready), .o_pending(pending), .o_overrun(overrun),
      .i_clear_overrun(clr));

   ramreader_stream #(.START_ADDR(14'd16383)) u_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_wbit(w_wbit), .o_rd_address(w_addr),
      .o_rden(w_rden), .i_q(w_q), .o_data(w_data), .o_valid(w_valid),
      .i_ready(w_ready), .o_pending(w_pending), .o_overrun(w_overrun),
      .i_clear_overrun(w_clr));

   function automatic logic [63:0] word_of(input logic [13:0] a);
      if (a == 14'd2) return 64'h0004_0003_0002_0001;
      return {4'hD, a[11:0], 4'hC, a[11:0], 4'hB, a[11:0], 4'hA, a[11:0]};
   endfunction

   // latency-2 RAM models, garbage except on the due cycle
   logic [63:0] p1, w_p1;
   always @(posedge clk) begin
      p1   <= rden   ? word_of(addr)   : 64'hBAD0_BAD1_BAD2_BAD3;
      q    <= p1;
      w_p1 <= w_rden ? word_of(w_addr) : 64'hBAD0_BAD1_BAD2_BAD3;
      w_q  <= w_p1;
   end

   // record read issues and accepted samples
   always @(negedge clk) if (rst_n) begin
      if (rden)            begin rd_q.push_back(addr); rd_cyc.push_back(cyc); end
      if (valid && ready)  begin hs_q.push_back(data); hs_cyc.push_back(cyc); end
      if (w_rden)          w_rd_q.push_back(w_addr);
      if (w_valid && w_ready) w_hs_q.push_back(w_data);
   end

   task automatic clear_logs();
      rd_q.delete(); rd_cyc.delete(); hs_q.delete(); hs_cyc.delete();
      w_rd_q.delete(); w_hs_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; wbit = 1'b0; clr = 1'b0; w_wbit = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_logs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (addr !== 14'd2) begin bad++; $display("FAIL rst_addr got %0d want 2", addr); end
      total++; if (rden !== 1'b0) begin bad++; $display("FAIL rst_rden got %b want 0", rden); end
      total++; if (data !== 16'h0) begin bad++; $display("FAIL rst_data got %h want 0000", data); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", valid); end
      total++; if (pending !== 15'd0) begin bad++; $display("FAIL rst_pending got %0d want 0", pending); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
      total++; if (w_addr !== 14'd16383) begin bad++; $display("FAIL rst_waddr got %0d want 16383", w_addr); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_logs();
   endtask

   task automatic test_single();
      logic [15:0] exp [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      ready = 1'b1; wbit = 1'b1;
      @(posedge clk); #1; wbit = 1'b0;
      for (int i = 0; i < 40 && hs_q.size() < 4; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (rd_q.size() !== 1) begin bad++; $display("FAIL single_nreads got %0d want 1", rd_q.size()); end
      total++; if (rd_q.size() > 0 && rd_q[0] !== 14'd2) begin bad++; $display("FAIL single_rdaddr got %0d want 2", rd_q[0]); end
      total++; if (hs_q.size() !== 4) begin bad++; $display("FAIL single_nhs got %0d want 4", hs_q.size()); end
      for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
         total++; if (hs_q[i] !== exp[i]) begin bad++; $display("FAIL single_lane%0d got %h want %h", i, hs_q[i], exp[i]); end
      end
      if (hs_q.size() == 4 && rd_cyc.size() > 0) begin
         total++; if (hs_cyc[0] - rd_cyc[0] !== 3) begin bad++; $display("FAIL single_latency got %0d want 3", hs_cyc[0] - rd_cyc[0]); end
         total++; if (hs_cyc[3] - hs_cyc[0] !== 3) begin bad++; $display("FAIL single_consec got %0d want 3", hs_cyc[3] - hs_cyc[0]); end
      end
      total++; if (pending !== 15'd0) begin bad++; $display("FAIL single_pending got %0d want 0", pending); end
      total++; if (addr !== 14'd3) begin bad++; $display("FAIL single_addr got %0d want 3", addr); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_valid_end got %b want 0", valid); end
      @(posedge clk); #1; clear_logs();
   endtask

   task automatic test_backpressure();
      logic [15:0] exp [4] = '{16'hA003, 16'hB003, 16'hC003, 16'hD003};
      logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic        pv = 1'b0, pr = 1'b0;
      logic [15:0] pd = '0;
      int          k = 0;
      ready = 1'b0; wbit = 1'b1;
      @(posedge clk); #1; wbit = 1'b0;
      for (int i = 0; i < 60 && hs_q.size() < 4; i++) begin
         @(negedge clk);
         if (pv && !pr) begin
            total++; if (valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got %b want 1", valid); end
            total++; if (data !== pd) begin bad++; $display("FAIL bp_hold_data got %h want %h", data, pd); end
         end
         pv = valid; pr = ready; pd = data;
         @(posedge clk); #1;
         if (valid) begin ready = pat[k % 4]; k++; end
      end
      ready = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++; if (hs_q.size() !== 4) begin bad++; $display("FAIL bp_nhs got %0d want 4", hs_q.size()); end
      for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
         total++; if (hs_q[i] !== exp[i]) begin bad++; $display("FAIL bp_lane%0d got %h want %h", i, hs_q[i], exp[i]); end
      end
      total++; if (addr !== 14'd4) begin bad++; $display("FAIL bp_addr got %0d want 4", addr); end
      @(posedge clk); #1; clear_logs();
   endtask

   task automatic test_simultaneous();
      do_reset();
      ready = 1'b1; wbit = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (rden !== 1'b1) begin bad++; $display("FAIL sim_rden got %b want 1", rden); end
      total++; if (pending !== 15'd1) begin bad++; $display("FAIL sim_pending_issue got %0d want 1", pending); end
      @(posedge clk); #1; wbit = 1'b0;
      @(negedge clk);
      total++; if (pending !== 15'd1) begin bad++; $display("FAIL sim_pending_after got %0d want 1", pending); end
      for (int i = 0; i < 60 && hs_q.size() < 8; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (rd_q.size() !== 2) begin bad++; $display("FAIL sim_nreads got %0d want 2", rd_q.size()); end
      if (rd_q.size() == 2) begin
         total++; if (rd_q[1] !== 14'd3) begin bad++; $display("FAIL sim_rdaddr2 got %0d want 3", rd_q[1]); end
         total++; if (rd_cyc[1] - rd_cyc[0] !== 7) begin bad++; $display("FAIL sim_period got %0d want 7", rd_cyc[1] - rd_cyc[0]); end
      end
      total++; if (pending !== 15'd0) begin bad++; $display("FAIL sim_pending_end got %0d want 0", pending); end
      @(posedge clk); #1; clear_logs();
   endtask

   task automatic test_wrap();
      logic [13:0] exp_a [3] = '{14'd16383, 14'd0, 14'd1};
      logic [15:0] exp_d [12] = '{16'hAFFF, 16'hBFFF, 16'hCFFF, 16'hDFFF,
                                  16'hA000, 16'hB000, 16'hC000, 16'hD000,
                                  16'hA001, 16'hB001, 16'hC001, 16'hD001};
      w_wbit = 1'b1;
      repeat (3) @(posedge clk);
      #1; w_wbit = 1'b0;
      for (int i = 0; i < 80 && w_hs_q.size() < 12; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (w_rd_q.size() !== 3) begin bad++; $display("FAIL wrap_nreads got %0d want 3", w_rd_q.size()); end
      for (int i = 0; i < 3 && i < w_rd_q.size(); i++) begin
         total++; if (w_rd_q[i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr%0d got %0d want %0d", i, w_rd_q[i], exp_a[i]); end
      end
      total++; if (w_hs_q.size() !== 12) begin bad++; $display("FAIL wrap_nhs got %0d want 12", w_hs_q.size()); end
      for (int i = 0; i < 12 && i < w_hs_q.size(); i++) begin
         total++; if (w_hs_q[i] !== exp_d[i]) begin bad++; $display("FAIL wrap_data%0d got %h want %h", i, w_hs_q[i], exp_d[i]); end
      end
      total++; if (w_addr !== 14'd2) begin bad++; $display("FAIL wrap_final_addr got %0d want 2", w_addr); end
      total++; if (w_pending !== 15'd0) begin bad++; $display("FAIL wrap_pending got %0d want 0", w_pending); end
      @(posedge clk); #1; clear_logs();
   endtask

   task automatic test_overrun();
      do_reset();
      ready = 1'b0; wbit = 1'b1;
      repeat (16385) @(posedge clk);
      #1; wbit = 1'b0;
      @(negedge clk);
      total++; if (pending !== 15'd16384) begin bad++; $display("FAIL ovr_pending_full got %0d want 16384", pending); end
      @(posedge clk); #1; wbit = 1'b1;
      @(posedge clk); #1; wbit = 1'b0;
      @(negedge clk);
      total++; if (pending !== 15'd16384) begin bad++; $display("FAIL ovr_pending_sat got %0d want 16384", pending); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got %b want 1", overrun); end
      total++; if (valid !== 1'b1 || data !== 16'h0001) begin bad++; $display("FAIL ovr_stalled_out got v=%b d=%h want v=1 d=0001", valid, data); end
      total++; if (rd_q.size() !== 1) begin bad++; $display("FAIL ovr_nreads got %0d want 1", rd_q.size()); end
      @(posedge clk); #1; clr = 1'b1;
      @(posedge clk); #1; clr = 1'b0;
      @(negedge clk);
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got %b want 0", overrun); end
      @(posedge clk); #1; clr = 1'b1; wbit = 1'b1;
      @(posedge clk); #1; clr = 1'b0; wbit = 1'b0;
      @(negedge clk);
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
      total++; if (pending !== 15'd16384) begin bad++; $display("FAIL ovr_pending_hold got %0d want 16384", pending); end
      @(posedge clk); #1; clear_logs();
   endtask

   task automatic test_reset_mid_send();
      int i;
      do_reset();
      ready = 1'b0; wbit = 1'b1;
      @(posedge clk); #1; wbit = 1'b0;
      for (i = 0; i < 20 && !valid; i++) @(negedge clk);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL mid_valid_timeout got %b want 1", valid); end
      @(posedge clk); #1; ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; ready = 1'b0;
      @(negedge clk);
      total++; if (data !== 16'h0003) begin bad++; $display("FAIL mid_lane2 got %h want 0003", data); end
      #2; rst_n = 1'b0;
      #1;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got %b want 0", valid); end
      total++; if (addr !== 14'd2) begin bad++; $display("FAIL mid_rst_addr got %0d want 2", addr); end
      @(negedge clk); rst_n = 1'b1;
      clear_logs();
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++; if (rd_q.size() !== 0) begin bad++; $display("FAIL mid_no_read got %0d want 0", rd_q.size()); end
      total++; if (pending !== 15'd0) begin bad++; $display("FAIL mid_pending got %0d want 0", pending); end
      total++; if (addr !== 14'd2) begin bad++; $display("FAIL mid_addr got %0d want 2", addr); end
      @(posedge clk); #1; wbit = 1'b1;
      @(posedge clk); #1; wbit = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (rd_q.size() !== 1 || rd_q[0] !== 14'd2) begin bad++; $display("FAIL mid_new_read got n=%0d want n=1 addr=2", rd_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_simultaneous();
      test_wrap();
      test_overrun();
      test_reset_mid_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
